// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types, SPI mode constants and cs_sel width helper
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // SPI modes encoded as {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    // A single chip select still needs a 1-bit index port
    function automatic int cs_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_master_param_if.sv
// rtl/spi_master_param_if.sv - request/status/pin bundle for spi_master_param
// Signals: wr, din, cs_sel, divisor, cpol, cpha (request); busy, done, dout
// (status); sck, mosi, miso, cs_n (SPI pins). SPI_LSBFIRST_EN adds lsb_first.
// Modport master: the requester and attached SPI slave. Modport slave: the SPI master block.
interface spi_master_param_if #(
    parameter int DATA_W = 8,
    parameter int NCS    = 1,
    parameter int DIV_W  = 8
) ();
    import spi_pkg::*;

    localparam int CS_W = cs_w(NCS);

    logic              wr;
    logic [DATA_W-1:0] din;
    logic [CS_W-1:0]   cs_sel;
    logic [DIV_W-1:0]  divisor;
    logic              cpol;
    logic              cpha;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] dout;
    logic              sck;
    logic              mosi;
    logic              miso;
    logic [NCS-1:0]    cs_n;
`ifdef SPI_LSBFIRST_EN
    logic              lsb_first;

    modport master (
        output wr, din, cs_sel, divisor, cpol, cpha, miso, lsb_first,
        input  busy, done, dout, sck, mosi, cs_n
    );
    modport slave (
        input  wr, din, cs_sel, divisor, cpol, cpha, miso, lsb_first,
        output busy, done, dout, sck, mosi, cs_n
    );
`else
    modport master (
        output wr, din, cs_sel, divisor, cpol, cpha, miso,
        input  busy, done, dout, sck, mosi, cs_n
    );
    modport slave (
        input  wr, din, cs_sel, divisor, cpol, cpha, miso,
        output busy, done, dout, sck, mosi, cs_n
    );
`endif

endinterface

// File: rtl/spi_clkgen.sv
// rtl/spi_clkgen.sv - half-period tick generator and sck edge counter
// Ports: clk, resetb (sync, active-low); i_start loads divisor and clears the
// edge count; i_run enables ticking; i_xfer lets ticks advance the edge count;
// i_div divisor; o_tick every divisor+1 cycles; o_lead marks a leading edge;
// o_last marks the final (2*DATA_W-th) edge.
module spi_clkgen #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             i_start,
    input  logic             i_run,
    input  logic             i_xfer,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick,
    output logic             o_lead,
    output logic             o_last
);
    localparam int EW = $clog2(2 * DATA_W);

    logic [DIV_W-1:0] r_div;
    logic [DIV_W:0]   r_cnt;
    logic [EW-1:0]    r_edge;

    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_div  <= '0;
            r_cnt  <= '0;
            r_edge <= '0;
        end else if (i_start) begin
            r_div  <= i_div;
            r_cnt  <= {1'b0, i_div};
            r_edge <= '0;
        end else if (o_tick) begin
            r_cnt <= {1'b0, r_div};
            if (i_xfer)
                r_edge <= o_last ? '0 : r_edge + EW'(1);
        end else if (i_run) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_tick = i_run && (r_cnt == '0);
    // Even-numbered edges (0, 2, ...) move sck away from its idle level
    assign o_lead = ~r_edge[0];
    assign o_last = (r_edge == EW'(2 * DATA_W - 1));

endmodule

// File: rtl/spi_master_param.sv
// rtl/spi_master_param.sv - parameterised SPI master: FSM, shift registers, pin drivers
// Ports: clk, resetb (sync, active-low); bus (spi_master_param_if.slave):
//   wr/din/cs_sel/divisor/cpol/cpha request, busy/done/dout status,
//   sck/mosi/miso/cs_n SPI pins.
// Macro SPI_LSBFIRST_EN: adds bus.lsb_first for LSB-first shifting.
module spi_master_param #(
    parameter int DATA_W = 8,
    parameter int NCS    = 1,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              resetb,
    spi_master_param_if.slave bus
);
    import spi_pkg::*;

    localparam int CS_W = cs_w(NCS);

    state_t            r_state, w_state_nxt;
    logic              r_cpol, r_cpha, r_done, r_sck, r_mosi;
    logic [CS_W-1:0]   r_cs_sel;
    logic [DATA_W-1:0] r_tx, r_rx, r_dout;
    logic [NCS-1:0]    w_cs_n;
    logic              w_lsb_wr, w_lsb;
    logic              w_busy, w_in_xfer, w_accept, w_tick, w_lead_edge, w_last_edge;
    logic              w_xfer_tick, w_lead, w_trail, w_sample, w_drive, w_finish;

`ifdef SPI_LSBFIRST_EN
    logic r_lsb;

    always_ff @(posedge clk) begin
        if (!resetb)
            r_lsb <= 1'b0;
        else if (w_accept)
            r_lsb <= bus.lsb_first;
    end

    assign w_lsb_wr = bus.lsb_first;
    assign w_lsb    = r_lsb;
`else
    assign w_lsb_wr = 1'b0;
    assign w_lsb    = 1'b0;
`endif

    assign w_busy    = (r_state != IDLE);
    assign w_in_xfer = (r_state == XFER);
    // The done cycle is already IDLE, so a wr there must be rejected explicitly
    assign w_accept  = (r_state == IDLE) && bus.wr && !r_done;

    spi_clkgen #(
        .DATA_W(DATA_W),
        .DIV_W (DIV_W)
    ) u_clkgen (
        .clk    (clk),
        .resetb (resetb),
        .i_start(w_accept),
        .i_run  (w_busy),
        .i_xfer (w_in_xfer),
        .i_div  (bus.divisor),
        .o_tick (w_tick),
        .o_lead (w_lead_edge),
        .o_last (w_last_edge)
    );

    assign w_xfer_tick = w_in_xfer && w_tick;
    assign w_lead      = w_xfer_tick && w_lead_edge;
    assign w_trail     = w_xfer_tick && !w_lead_edge;
    assign w_sample    = r_cpha ? w_trail : w_lead;
    // cpha=0 preloads the first bit at accept, so the final trailing edge has nothing left to drive
    assign w_drive     = r_cpha ? w_lead : (w_trail && !w_last_edge);
    assign w_finish    = (r_state == HOLD) && w_tick;

    always_ff @(posedge clk) begin
        if (!resetb)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)                w_state_nxt = SETUP;
            SETUP:   if (w_tick)                  w_state_nxt = XFER;
            XFER:    if (w_tick && w_last_edge)   w_state_nxt = HOLD;
            HOLD:    if (w_tick)                  w_state_nxt = IDLE;
            default:                              w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_cpol   <= 1'b0;
            r_cpha   <= 1'b0;
            r_cs_sel <= '0;
            r_tx     <= '0;
            r_rx     <= '0;
            r_dout   <= '0;
            r_done   <= 1'b0;
            r_sck    <= 1'b0;
            r_mosi   <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_accept) begin
                r_cpol   <= bus.cpol;
                r_cpha   <= bus.cpha;
                r_cs_sel <= bus.cs_sel;
                r_sck    <= bus.cpol;
                r_rx     <= '0;
                if (!bus.cpha) begin
                    r_mosi <= w_lsb_wr ? bus.din[0] : bus.din[DATA_W-1];
                    r_tx   <= w_lsb_wr ? (bus.din >> 1) : (bus.din << 1);
                end else begin
                    r_tx   <= bus.din;
                end
            end else begin
                if (w_xfer_tick)
                    r_sck <= ~r_sck;
                if (w_drive) begin
                    r_mosi <= w_lsb ? r_tx[0] : r_tx[DATA_W-1];
                    r_tx   <= w_lsb ? (r_tx >> 1) : (r_tx << 1);
                end
                if (w_sample)
                    r_rx <= w_lsb ? {bus.miso, r_rx[DATA_W-1:1]}
                                  : {r_rx[DATA_W-2:0], bus.miso};
                if (w_finish)
                    r_dout <= r_rx;
            end
        end
    end

    // Out-of-range cs_sel matches no line, so the transfer runs with all selects high
    always_comb begin
        w_cs_n = '1;
        for (int i = 0; i < NCS; i++)
            if (w_busy && (r_cs_sel == CS_W'(i)))
                w_cs_n[i] = 1'b0;
    end

    assign bus.busy = w_busy;
    assign bus.done = r_done;
    assign bus.dout = r_dout;
    assign bus.sck  = r_sck;
    assign bus.mosi = r_mosi;
    assign bus.cs_n = w_cs_n;

endmodule

// File: tb/tb_spi_master_param.sv
// tb/tb_spi_master_param.sv - self-checking bench for spi_master_param
module tb_spi_master_param;
    import spi_pkg::*;

    localparam int W     = 8;
    localparam int NCS_P = 6;
    localparam int DW    = 4;
    localparam int CS_W  = cs_w(NCS_P);

    logic clk = 1'b0;
    logic resetb;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    spi_master_param_if #(.DATA_W(W), .NCS(NCS_P), .DIV_W(DW)) bus ();

    spi_master_param #(.DATA_W(W), .NCS(NCS_P), .DIV_W(DW)) dut (
        .clk   (clk),
        .resetb(resetb),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_lsb(input bit v);
`ifdef SPI_LSBFIRST_EN
        bus.lsb_first = v;
`endif
    endtask

    // miso_mode: 0 random, 1 loopback from mosi, 2 held high.
    // Entered and left on a falling clk edge.
    task automatic run_xfer(input logic [W-1:0] din, input int div, input logic [1:0] mode,
                            input int sel, input int miso_mode, input bit lsb,
                            input bit poke_busy, input bit poke_done);
        int d, n, tog, k, nbits;
        int e_busy, e_done, e_cs, e_sck;
        logic cpol, cpha, exp_sck, prev_miso;
        logic [NCS_P-1:0] exp_cs;
        logic [W-1:0] mo_word, mi_word;
        cpol = mode[1];
        cpha = mode[0];
        d = div + 1;
        n = (2 * W + 2) * d;
        exp_cs = '1;
        if (sel < NCS_P) exp_cs[sel] = 1'b0;
        e_busy = 0; e_done = 0; e_cs = 0; e_sck = 0; nbits = 0;
        mo_word = '0; mi_word = '0;

        bus.din     = din;
        bus.divisor = DW'(div);
        bus.cpol    = cpol;
        bus.cpha    = cpha;
        bus.cs_sel  = CS_W'(sel);
        drive_lsb(lsb);
        bus.wr      = 1'b1;
        prev_miso   = bus.miso;
        @(negedge clk);

        // t = rising edges since the accepting edge
        for (int t = 0; t <= n + 2; t++) begin
            if (t > 0) @(negedge clk);
            tog = t / d - 1;
            if (tog < 0) tog = 0;
            if (tog > 2 * W) tog = 2 * W;
            exp_sck = cpol ^ tog[0];
            if (bus.busy !== (t < n)) e_busy++;
            if (bus.done !== (t == n)) e_done++;
            if (bus.cs_n !== ((t < n) ? exp_cs : {NCS_P{1'b1}})) e_cs++;
            if (bus.sck !== exp_sck) e_sck++;
            k = t / d - 1;
            if ((t % d == 0) && k >= 1 && k <= 2 * W && ((k % 2 == 1) == (cpha == 1'b0))) begin
                if (nbits < W) begin
                    mo_word[lsb ? nbits : W - 1 - nbits] = bus.mosi;
                    mi_word[lsb ? nbits : W - 1 - nbits] = prev_miso;
                end
                nbits++;
            end
            bus.wr = 1'b0;
            if (t == 0) begin
                bus.din     = W'($urandom);
                bus.divisor = DW'($urandom);
                bus.cpol    = 1'($urandom);
                bus.cpha    = 1'($urandom);
                bus.cs_sel  = CS_W'($urandom);
                drive_lsb(1'($urandom));
            end
            if (poke_busy && t == 3) begin
                bus.din = '0;
                bus.wr  = 1'b1;
            end
            if (poke_done && t == n) bus.wr = 1'b1;
            case (miso_mode)
                1:       bus.miso = bus.mosi;
                2:       bus.miso = 1'b1;
                default: bus.miso = 1'($urandom);
            endcase
            prev_miso = bus.miso;
        end

        check("busy_wave", e_busy, 0);
        check("done_wave", e_done, 0);
        check("cs_wave", e_cs, 0);
        check("sck_wave", e_sck, 0);
        check("nbits", nbits, W);
        check("mosi_word", mo_word, din);
        check("dout", bus.dout, mi_word);
        if (miso_mode == 1) check("loop_dout", bus.dout, din);
    endtask

    task automatic reset_mid();
        int ndone, nbusy;
        bus.din = 8'h6B; bus.divisor = DW'(1); bus.cpol = 1'b1; bus.cpha = 1'b0;
        bus.cs_sel = CS_W'(1);
        drive_lsb(1'b0);
        bus.wr = 1'b1;
        @(negedge clk);
        bus.wr = 1'b0;
        repeat (6) @(negedge clk);
        resetb = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_done", bus.done, 0);
        check("rst_mid_dout", bus.dout, 0);
        check("rst_mid_sck", bus.sck, 0);
        check("rst_mid_cs", bus.cs_n, {NCS_P{1'b1}});
        resetb = 1'b1;
        ndone = 0; nbusy = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.done) ndone++;
            if (bus.busy) nbusy++;
        end
        check("rst_quiet_done", ndone, 0);
        check("rst_quiet_busy", nbusy, 0);
    endtask

    initial begin
        bus.wr = 1'b0; bus.din = '0; bus.cs_sel = '0; bus.divisor = '0;
        bus.cpol = 1'b0; bus.cpha = 1'b0; bus.miso = 1'b0;
        drive_lsb(1'b0);
        resetb = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_dout", bus.dout, 0);
        check("rst_sck", bus.sck, 0);
        check("rst_mosi", bus.mosi, 0);
        check("rst_cs", bus.cs_n, {NCS_P{1'b1}});
        resetb = 1'b1;
        @(negedge clk);

        run_xfer(8'h37, 1,  MODE0, 0, 2, 1'b0, 1'b0, 1'b0);
        check("t1_dout_ff", bus.dout, 8'hFF);
        run_xfer(8'hA5, 0,  MODE3, 1, 1, 1'b0, 1'b0, 1'b0);
        run_xfer(8'h5C, 1,  MODE1, 2, 0, 1'b0, 1'b1, 1'b1);
        run_xfer(8'h81, 0,  MODE2, 7, 0, 1'b0, 1'b0, 1'b0);
        run_xfer(8'h00, 2,  MODE0, 5, 2, 1'b0, 1'b0, 1'b0);
        run_xfer(8'hC3, 15, MODE0, 5, 1, 1'b0, 1'b0, 1'b0);
`ifdef SPI_LSBFIRST_EN
        run_xfer(8'h34, 1,  MODE1, 3, 1, 1'b1, 1'b0, 1'b0);
        run_xfer(8'hE1, 0,  MODE2, 0, 0, 1'b1, 1'b1, 1'b0);
`endif
        reset_mid();

        for (int r = 0; r < 16; r++) begin
            bit lsb_r;
            lsb_r = 1'b0;
`ifdef SPI_LSBFIRST_EN
            lsb_r = 1'($urandom);
`endif
            run_xfer(W'($urandom), $urandom_range(0, 3), 2'($urandom),
                     $urandom_range(0, 7), $urandom_range(0, 2), lsb_r,
                     1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
